// File: rtl/sudoku_pkg.sv
// Shared constants, digit codes and FSM encoding for the sudoku mask decoder.
package sudoku_pkg;

  localparam int N      = 9;
  localparam int CELLS  = 81;
  localparam int MASK_W = 729;

  localparam logic [3:0] DIG_UNRES    = 4'd0;
  localparam logic [3:0] DIG_CONFLICT = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sudoku_cell_decode.sv
// Classifies one cell's 9 exclusion bits into a digit code plus solved/conflict flags.
module sudoku_cell_decode
  import sudoku_pkg::*;
(
  input  logic [N-1:0] bits,
  output logic [3:0]   digit,
  output logic         solved,
  output logic         conflict
);

  logic [3:0] n_clear;
  logic [3:0] pos;

  always_comb begin
    n_clear = '0;
    pos     = '0;
    for (int d = 0; d < N; d++) begin
      if (!bits[d]) begin
        n_clear = n_clear + 4'd1;
        pos     = 4'(d);
      end
    end
    solved   = (n_clear == 4'd1);
    conflict = (n_clear == 4'd0);
    if (solved) begin
      digit = pos + 4'd1;
    end else if (conflict) begin
      digit = DIG_CONFLICT;
    end else begin
      digit = DIG_UNRES;
    end
  end

endmodule

// File: rtl/sudoku_mask_decode.sv
// Captures one 729-bit elimination mask and streams the 81 cell results serially,
// one cell per cycle, over a valid/ready port, then pulses done with a frame summary.
module sudoku_mask_decode
  import sudoku_pkg::*;
#(
  parameter bit SKIP_UNRESOLVED   = 1'b0,
  parameter bit ABORT_ON_CONFLICT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MASK_W-1:0] puzzle_mask_bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_x,
  output logic [3:0]        out_y,
  output logic [3:0]        out_digit,
  output logic              done,
  output logic [6:0]        solved_count,
  output logic              conflict,
  output logic [1:0]        state_dbg
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_* stay stable while out_valid=1 and out_ready=0. A frame transfers
  // on a rising edge where in_valid && in_ready.

  state_t state;
  state_t state_nxt;

  logic [CELLS-1:0][N-1:0] mask_q;
  logic [6:0]              c_q;
  logic [3:0]              x_q;
  logic [3:0]              y_q;

  logic [N-1:0] cell_bits;
  logic [3:0]   cell_digit;
  logic         cell_solved;
  logic         cell_conflict;

  logic free;
  logic emit;
  logic last_cell;
  logic abort_hit;

  assign cell_bits = mask_q[c_q];

  sudoku_cell_decode u_cell (
    .bits     (cell_bits),
    .digit    (cell_digit),
    .solved   (cell_solved),
    .conflict (cell_conflict)
  );

  assign free      = !out_valid || out_ready;
  assign emit      = !SKIP_UNRESOLVED || (cell_digit != DIG_UNRES);
  assign last_cell = (c_q == 7'(CELLS - 1));
  assign abort_hit = ABORT_ON_CONFLICT && cell_conflict;

  assign in_ready  = (state == ST_IDLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_SCAN;
      ST_SCAN:  if (free && (last_cell || abort_hit)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (free) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Mask contents are don't-care outside a frame, so the capture register has no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      mask_q <= puzzle_mask_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      c_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      out_valid    <= 1'b0;
      out_x        <= '0;
      out_y        <= '0;
      out_digit    <= '0;
      solved_count <= '0;
      conflict     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            c_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            solved_count <= '0;
            conflict     <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (free) begin
            out_valid <= emit;
            if (emit) begin
              out_x     <= x_q;
              out_y     <= y_q;
              out_digit <= cell_digit;
            end
            solved_count <= solved_count + 7'(cell_solved);
            conflict     <= conflict | cell_conflict;
            c_q          <= c_q + 7'd1;
            // y walks the row, x advances on wrap; avoids any divide by 9.
            if (y_q == 4'(N - 1)) begin
              y_q <= '0;
              x_q <= x_q + 4'd1;
            end else begin
              y_q <= y_q + 4'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (free) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
